// File: rtl/noekeon_data_out_serializer_pkg.sv
// Shared Noekeon definitions used by the data-out serializer.
package noekeon_data_out_serializer_pkg;

  // Width of one Noekeon state/block in bits.
  localparam int BLOCK_W = 128;

  // Serializer state: idle, or a block is being presented word by word.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } serState_e;

  // Number of words a block splits into for a given word width.
  function automatic int wordsPerBlock(input int wordW);
    return BLOCK_W / wordW;
  endfunction

endpackage

// File: rtl/noekeon_data_out_serializer_if.sv
// Block-in / word-out bus of the Noekeon data-out serializer.
interface noekeon_data_out_serializer_if #(
  parameter int WORD_W = 32
);
  import noekeon_data_out_serializer_pkg::*;

  logic [BLOCK_W-1:0] inBlock;
  logic               inBlockValid;
  logic               outBlockReady;
  logic [WORD_W-1:0]  outWord;
  logic               outWordValid;
  logic               inWordReady;
  logic               outLast;
  logic               outOverflow;
  logic               inClearOverflow;

  // Block producer and word sink side (drives the serializer inputs).
  modport master (
    output inBlock, inBlockValid, inWordReady, inClearOverflow,
    input  outBlockReady, outWord, outWordValid, outLast, outOverflow
  );

  // Serializer side.
  modport slave (
    input  inBlock, inBlockValid, inWordReady, inClearOverflow,
    output outBlockReady, outWord, outWordValid, outLast, outOverflow
  );

endinterface

// File: rtl/noekeon_data_out_serializer.sv
// Streams finished 128-bit Noekeon blocks out as WORD_W-bit words, MSW first.
// One further block waits in a pending buffer so consecutive blocks leave no
// bubble on the word bus; a block arriving while that buffer is full is
// dropped and flagged in a sticky overflow bit.
module noekeon_data_out_serializer
  import noekeon_data_out_serializer_pkg::*;
#(
  parameter int WORD_W = 32   // 8, 16, 32 or 64
) (
  input logic                           inClk,
  input logic                           inResetN,
  noekeon_data_out_serializer_if.slave  bus
);

  localparam int N     = wordsPerBlock(WORD_W);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  serState_e           state;
  logic [BLOCK_W-1:0]  shiftReg;
  logic [BLOCK_W-1:0]  pendReg;
  logic                pendingFull;
  logic [IDX_W-1:0]    idx;
  logic                overflow;

  logic                wordValid;
  logic                wordHs;
  logic                lastHs;
  logic                dropBlock;
  logic [BLOCK_W-1:0]  shiftedReg;

  // All outputs come straight from registers; none depends on an input.
  assign wordValid          = (state == SHIFT);
  assign bus.outWordValid   = wordValid;
  assign bus.outWord        = shiftReg[BLOCK_W-1 -: WORD_W];
  assign bus.outLast        = wordValid && (idx == LAST_IDX);
  assign bus.outBlockReady  = !pendingFull;
  assign bus.outOverflow    = overflow;

  assign wordHs     = wordValid && bus.inWordReady;
  assign lastHs     = wordHs && (idx == LAST_IDX);
  // A full pending buffer rejects the block even if it empties this cycle,
  // because outBlockReady was already low when the block was offered.
  assign dropBlock  = bus.inBlockValid && pendingFull;
  assign shiftedReg = {shiftReg[BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};

  // Serializer state machine: load, shift, pending buffer and overflow flag.
  always_ff @(posedge inClk) begin
    if (!inResetN) begin
      state       <= IDLE;
      shiftReg    <= {BLOCK_W{1'b0}};
      pendReg     <= {BLOCK_W{1'b0}};
      pendingFull <= 1'b0;
      idx         <= {IDX_W{1'b0}};
      overflow    <= 1'b0;
    end else begin
      if (dropBlock) begin
        overflow <= 1'b1;
      end else if (bus.inClearOverflow) begin
        overflow <= 1'b0;
      end else begin
        overflow <= overflow;
      end

      case (state)
        IDLE: begin
          if (bus.inBlockValid) begin
            shiftReg <= bus.inBlock;
            idx      <= {IDX_W{1'b0}};
            state    <= SHIFT;
          end else begin
            state    <= IDLE;
          end
        end

        SHIFT: begin
          if (lastHs) begin
            idx <= {IDX_W{1'b0}};
            if (pendingFull) begin
              // Pending block follows directly; any new strobe was dropped.
              shiftReg    <= pendReg;
              pendingFull <= 1'b0;
            end else if (bus.inBlockValid) begin
              // Nothing waiting: the new block bypasses the pending buffer.
              shiftReg    <= bus.inBlock;
            end else begin
              shiftReg    <= shiftedReg;
              state       <= IDLE;
            end
          end else begin
            if (wordHs) begin
              shiftReg <= shiftedReg;
              idx      <= idx + IDX_W'(1);
            end else begin
              shiftReg <= shiftReg;
            end
            if (bus.inBlockValid && !pendingFull) begin
              pendReg     <= bus.inBlock;
              pendingFull <= 1'b1;
            end else begin
              pendingFull <= pendingFull;
            end
          end
        end

        default: begin
          state       <= IDLE;
          idx         <= {IDX_W{1'b0}};
          pendingFull <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noekeon_data_out_serializer.sv
// Scoreboard bench for the Noekeon data-out serializer (WORD_W = 32).
module tb_noekeon_data_out_serializer;

  typedef struct {
    logic [31:0] word;
    logic        last;
  } expEntry_t;

  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_B = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] BLK_C = 128'hDEADBEEF_CAFEF00D_0BADC0DE_12345678;
  localparam logic [127:0] BLK_D = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;

  logic clk;
  logic inResetN;
  int   nChecks;
  int   nFails;
  expEntry_t expQ[$];

  noekeon_data_out_serializer_if #(.WORD_W(32)) bus ();

  noekeon_data_out_serializer #(.WORD_W(32)) dut (
    .inClk    (clk),
    .inResetN (inResetN),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3);
    expQ.push_back('{word: w0, last: 1'b0});
    expQ.push_back('{word: w1, last: 1'b0});
    expQ.push_back('{word: w2, last: 1'b0});
    expQ.push_back('{word: w3, last: 1'b1});
  endtask

  task automatic strobe(input logic [127:0] blk);
    bus.inBlock      = blk;
    bus.inBlockValid = 1'b1;
    tick();
    bus.inBlockValid = 1'b0;
  endtask

  // Tick until the scoreboard is empty, bounded by a cycle budget.
  task automatic drain(input string name);
    int budget;
    budget = 0;
    while (expQ.size() != 0 && budget < 200) begin
      tick();
      budget++;
    end
    check(name, 128'(expQ.size()), 128'd0);
  endtask

  // Monitor: pops the scoreboard on each accepted word; checks stall stability.
  initial begin
    logic        stalled;
    logic [31:0] prevWord;
    expEntry_t   e;
    stalled  = 1'b0;
    prevWord = 32'h0;
    forever begin
      @(negedge clk);
      if (stalled) begin
        check("stall_valid", 128'(bus.outWordValid), 128'd1);
        check("stall_word", 128'(bus.outWord), 128'(prevWord));
      end
      if (inResetN && bus.outWordValid && bus.inWordReady) begin
        if (expQ.size() == 0) begin
          check("unexpected_word", 128'(bus.outWord), 128'h0);
        end else begin
          e = expQ.pop_front();
          check("word", 128'(bus.outWord), 128'(e.word));
          check("last", 128'(bus.outLast), 128'(e.last));
        end
      end
      stalled  = inResetN && bus.outWordValid && !bus.inWordReady;
      prevWord = bus.outWord;
    end
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    nChecks             = 0;
    nFails              = 0;
    inResetN            = 1'b0;
    bus.inBlock         = 128'h0;
    bus.inBlockValid    = 1'b0;
    bus.inWordReady     = 1'b0;
    bus.inClearOverflow = 1'b0;
    tick();
    tick();
    check("rst_valid", 128'(bus.outWordValid), 128'd0);
    check("rst_last", 128'(bus.outLast), 128'd0);
    check("rst_word", 128'(bus.outWord), 128'd0);
    check("rst_blkready", 128'(bus.outBlockReady), 128'd1);
    check("rst_overflow", 128'(bus.outOverflow), 128'd0);
    inResetN = 1'b1;
    tick();

    // Single block, sink always ready: word 0 valid the cycle after the strobe.
    bus.inWordReady = 1'b1;
    pushExp(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
    strobe(BLK_A);
    check("lat_valid", 128'(bus.outWordValid), 128'd1);
    check("lat_word0", 128'(bus.outWord), 128'h00112233);
    drain("drain_single");
    check("single_idle", 128'(bus.outWordValid), 128'd0);

    // Two blocks back to back: eight words with no gap, ready low while PB full.
    pushExp(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
    pushExp(32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210);
    strobe(BLK_A);
    strobe(BLK_B);
    for (int i = 0; i < 7; i++) begin
      check("b2b_valid", 128'(bus.outWordValid), 128'd1);
      check("b2b_blkready", 128'(bus.outBlockReady), (i < 3) ? 128'd0 : 128'd1);
      tick();
    end
    drain("drain_b2b");
    check("b2b_idle", 128'(bus.outWordValid), 128'd0);

    // Sink toggling ready every cycle.
    bus.inWordReady = 1'b0;
    pushExp(32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'hF0F0F0F0);
    strobe(BLK_D);
    for (int i = 0; i < 40 && expQ.size() != 0; i++) begin
      bus.inWordReady = ~bus.inWordReady;
      tick();
    end
    check("toggle_drained", 128'(expQ.size()), 128'd0);
    bus.inWordReady = 1'b1;
    tick();
    check("toggle_idle", 128'(bus.outWordValid), 128'd0);

    // Stalled sink, three blocks: third dropped, overflow sticky behaviour.
    bus.inWordReady = 1'b0;
    pushExp(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
    pushExp(32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210);
    strobe(BLK_A);
    strobe(BLK_B);
    check("ovf_blkready", 128'(bus.outBlockReady), 128'd0);
    check("ovf_before", 128'(bus.outOverflow), 128'd0);
    strobe(BLK_C);
    check("ovf_set", 128'(bus.outOverflow), 128'd1);
    tick();
    tick();
    check("ovf_hold_word", 128'(bus.outWord), 128'h00112233);
    bus.inClearOverflow = 1'b1;
    tick();
    bus.inClearOverflow = 1'b0;
    check("ovf_clear", 128'(bus.outOverflow), 128'd0);
    bus.inClearOverflow = 1'b1;
    strobe(BLK_D);
    bus.inClearOverflow = 1'b0;
    check("ovf_set_wins", 128'(bus.outOverflow), 128'd1);
    bus.inClearOverflow = 1'b1;
    tick();
    bus.inClearOverflow = 1'b0;
    check("ovf_clear2", 128'(bus.outOverflow), 128'd0);
    bus.inWordReady = 1'b1;
    drain("drain_ovf");
    check("ovf_idle", 128'(bus.outWordValid), 128'd0);

    // Last-word handshake with PB empty and a same-cycle strobe: no idle cycle.
    pushExp(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
    pushExp(32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210);
    strobe(BLK_A);
    check("byp_last0", 128'(bus.outLast), 128'd0);
    tick();
    tick();
    tick();
    check("byp_last3", 128'(bus.outLast), 128'd1);
    check("byp_blkready", 128'(bus.outBlockReady), 128'd1);
    strobe(BLK_B);
    check("byp_valid", 128'(bus.outWordValid), 128'd1);
    check("byp_word0", 128'(bus.outWord), 128'h01234567);
    drain("drain_byp");
    check("byp_idle", 128'(bus.outWordValid), 128'd0);

    // Reset during word 2 of a block with PB full.
    bus.inWordReady = 1'b0;
    expQ.push_back('{word: 32'h00112233, last: 1'b0});
    expQ.push_back('{word: 32'h44556677, last: 1'b0});
    strobe(BLK_A);
    strobe(BLK_B);
    bus.inWordReady = 1'b1;
    tick();
    tick();
    bus.inWordReady = 1'b0;
    check("mid_word2", 128'(bus.outWord), 128'h8899AABB);
    check("mid_pbfull", 128'(bus.outBlockReady), 128'd0);
    inResetN = 1'b0;
    tick();
    check("mid_rst_valid", 128'(bus.outWordValid), 128'd0);
    check("mid_rst_last", 128'(bus.outLast), 128'd0);
    check("mid_rst_word", 128'(bus.outWord), 128'd0);
    check("mid_rst_blkready", 128'(bus.outBlockReady), 128'd1);
    check("mid_rst_overflow", 128'(bus.outOverflow), 128'd0);
    check("mid_rst_queue", 128'(expQ.size()), 128'd0);
    inResetN = 1'b1;
    tick();
    check("post_rst_idle", 128'(bus.outWordValid), 128'd0);
    bus.inWordReady = 1'b1;
    pushExp(32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADC0DE, 32'h12345678);
    strobe(BLK_C);
    drain("drain_post_rst");
    check("post_rst_end", 128'(bus.outWordValid), 128'd0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
